// File: rtl/pnr_bus_initiator_if.sv
// Command, response and PNR system-bus signal bundle for pnr_bus_initiator.
// master = the initiator's view, slave = the sequencer/target side.
interface pnr_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/pnr_bus_initiator.sv
// Single-outstanding PNR system-bus initiator (command -> bus -> response).
// Define PNR_BUS_INIT_TIMEOUT_EN to include the WAIT-state watchdog.
module pnr_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ADDR_MASK      = 32'h000F_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  pnr_bus_initiator_if.master  bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_write;
  logic [31:0] r_sys_addr;
  logic [31:0] r_sys_wdata;
  logic        r_wen;
  logic        r_ren;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rsp_timeout;
  logic        r_busy;

`ifdef PNR_BUS_INIT_TIMEOUT_EN
  localparam logic [15:0] LP_TO = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_wdog;
  logic [15:0] w_wdog_nxt;
  assign w_wdog_nxt = (r_wdog == 16'hFFFF) ? r_wdog : r_wdog + 16'd1;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_write       <= 1'b0;
      r_sys_addr    <= '0;
      r_sys_wdata   <= '0;
      r_wen         <= 1'b0;
      r_ren         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
`ifdef PNR_BUS_INIT_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_wen <= 1'b0;
      r_ren <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // cmd_ready comes up one cycle after reset release
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_write     <= bus.cmd_write;
            r_sys_addr  <= bus.cmd_addr & ADDR_MASK;
            r_sys_wdata <= bus.cmd_wdata;
            r_wen       <= bus.cmd_write;
            r_ren       <= ~bus.cmd_write;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef PNR_BUS_INIT_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.sys_ack) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_write ? '0 : bus.sys_rdata;
            r_rsp_err     <= bus.sys_err;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end
`ifdef PNR_BUS_INIT_TIMEOUT_EN
          else if (w_wdog_nxt >= LP_TO) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wdog <= w_wdog_nxt;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.sys_addr    = r_sys_addr;
  assign bus.sys_wdata   = r_sys_wdata;
  assign bus.sys_wen     = r_wen;
  assign bus.sys_ren     = r_ren;
  assign busy            = r_busy;

endmodule

// File: tb/tb_pnr_bus_initiator.sv
// Directed scoreboard bench for pnr_bus_initiator.
// Timeout checks run only when PNR_BUS_INIT_TIMEOUT_EN is defined.
module tb_pnr_bus_initiator;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic clk;
  logic rstn;
  logic busy;
  logic ack_en;
  logic man_ack;
  logic t_ack;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  int   n_push;
  int   n_rsp;

  pnr_bus_initiator_if bus_if ();

  pnr_bus_initiator #(
    .TIMEOUT_CYCLES (16),
    .ADDR_MASK      (32'h000F_FFFF)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_if.master),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered target: acks the cycle after a strobe
  always @(posedge clk)
    t_ack <= ack_en && (bus_if.sys_wen || bus_if.sys_ren);
  assign bus_if.sys_ack = t_ack | man_ack;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // response monitor: sampled mid-cycle, handshake completes at next edge
  always @(negedge clk) begin
    if (rstn && bus_if.rsp_valid && bus_if.rsp_ready) begin
      exp_t e;
      n_rsp++;
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_rsp: got %0d queued expected 1", q.size());
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_rdata", bus_if.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(bus_if.rsp_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] rd, input logic er,
                      input logic tm);
    q.push_back({rd, er, tm});
    n_push++;
  endtask

  task automatic send(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic hold);
    int k = 0;
    while (!bus_if.cmd_ready && k < 50) begin
      cyc();
      k++;
    end
    chk("cmd_ready_wait", 32'(k < 50), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    cyc();
    if (!hold) bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || bus_if.rsp_valid) && k < 100) begin
      cyc();
      k++;
    end
    chk("idle_wait", 32'(k < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $error("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    int seen;
    n_cmp = 0; n_err = 0; n_push = 0; n_rsp = 0;
    rstn = 1'b0; ack_en = 1'b1; man_ack = 1'b0;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr = '0; bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b1;
    bus_if.sys_rdata = '0; bus_if.sys_err = 1'b0;

    cyc(); cyc();
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
    chk("rst_rsp_err", 32'(bus_if.rsp_err), 0);
    chk("rst_rsp_tmo", 32'(bus_if.rsp_timeout), 0);
    chk("rst_sys_addr", bus_if.sys_addr, 0);
    chk("rst_sys_wdata", bus_if.sys_wdata, 0);
    chk("rst_strobes", {30'd0, bus_if.sys_wen, bus_if.sys_ren}, 0);
    chk("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    cyc();
    chk("cmd_ready_up", 32'(bus_if.cmd_ready), 1);

    // write, ack one cycle after strobe
    push(32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h0000_000C, 32'h0000_1234, 1'b0);
    chk("wr_wen", 32'(bus_if.sys_wen), 1);
    chk("wr_ren", 32'(bus_if.sys_ren), 0);
    chk("wr_addr", bus_if.sys_addr, 32'h0000_000C);
    chk("wr_wdata", bus_if.sys_wdata, 32'h0000_1234);
    chk("wr_busy", 32'(busy), 1);
    cyc();
    chk("wr_wen_pulse", 32'(bus_if.sys_wen), 0);
    chk("wr_ack", 32'(bus_if.sys_ack), 1);
    cyc();
    chk("wr_rsp_lat", 32'(bus_if.rsp_valid), 1);
    cyc();
    chk("wr_idle_rdy", 32'(bus_if.cmd_ready), 1);
    chk("wr_idle_busy", 32'(busy), 0);

    // read
    bus_if.sys_rdata = 32'h0000_2ABC;
    push(32'h0000_2ABC, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 1'b0);
    chk("rd_ren", 32'(bus_if.sys_ren), 1);
    chk("rd_wen", 32'(bus_if.sys_wen), 0);
    chk("rd_addr", bus_if.sys_addr, 32'h0000_0008);
    cyc();
    chk("rd_ren_pulse", 32'(bus_if.sys_ren), 0);
    wait_idle();

    // non-responding target
    ack_en = 1'b0;
`ifdef PNR_BUS_INIT_TIMEOUT_EN
    push(32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    k = 0;
    while (!bus_if.rsp_valid && k < 100) begin
      cyc();
      k++;
    end
    chk("tmo_latency", k, 17);
    chk("tmo_flag", 32'(bus_if.rsp_timeout), 1);
    chk("tmo_err", 32'(bus_if.rsp_err), 1);
    cyc();
    repeat (5) cyc();
    bus_if.sys_rdata = 32'hDEAD_BEEF;
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus_if.rsp_valid) seen++;
      cyc();
    end
    chk("late_ack_rsp", seen, 0);
    chk("late_ack_busy", 32'(busy), 0);
`else
    send(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    seen = 0;
    repeat (20) begin
      if (bus_if.rsp_valid) seen++;
      cyc();
    end
    chk("noack_rsp", seen, 0);
    chk("noack_busy", 32'(busy), 1);
    bus_if.sys_rdata = 32'h0000_55AA;
    push(32'h0000_55AA, 1'b0, 1'b0);
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0;
    chk("late_ack_rsp", 32'(bus_if.rsp_valid), 1);
    chk("late_ack_tmo", 32'(bus_if.rsp_timeout), 0);
`endif
    wait_idle();
    ack_en = 1'b1;

    // response back-pressure with a queued command waiting
    bus_if.rsp_ready = 1'b0;
    bus_if.sys_rdata = 32'h0BAD_F00D;
    push(32'h0BAD_F00D, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0004, 32'h0, 1'b1);
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 32'h0000_0020;
    bus_if.cmd_wdata = 32'h0000_CAFE;
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus_if.rsp_valid), 1);
      chk("bp_rdata", bus_if.rsp_rdata, 32'h0BAD_F00D);
      chk("bp_cmd_ready", 32'(bus_if.cmd_ready), 0);
      chk("bp_no_issue", 32'(bus_if.sys_wen), 0);
      bus_if.sys_rdata = 32'h0;
      if (i < 9) cyc();
    end
    push(32'h0, 1'b0, 1'b0);
    bus_if.rsp_ready = 1'b1;
    cyc();
    chk("bp_rdy_back", 32'(bus_if.cmd_ready), 1);
    chk("bp_valid_low", 32'(bus_if.rsp_valid), 0);
    cyc();
    bus_if.cmd_valid = 1'b0;
    chk("bp_next_wen", 32'(bus_if.sys_wen), 1);
    chk("bp_next_addr", bus_if.sys_addr, 32'h0000_0020);
    chk("bp_next_data", bus_if.sys_wdata, 32'h0000_CAFE);
    wait_idle();

    // address mask and target error
    bus_if.sys_err = 1'b1;
    push(32'h0, 1'b1, 1'b0);
    send(1'b1, 32'hABC0_0040, 32'h0000_0001, 1'b0);
    chk("mask_addr", bus_if.sys_addr, 32'h0000_0040);
    wait_idle();
    bus_if.sys_err = 1'b0;

    // asynchronous reset during WAIT
    ack_en = 1'b0;
    send(1'b0, 32'h0000_0030, 32'h0, 1'b0);
    cyc();
    chk("rw_busy", 32'(busy), 1);
    #1 rstn = 1'b0;
    #1;
    chk("rw_busy_clr", 32'(busy), 0);
    chk("rw_cmd_ready", 32'(bus_if.cmd_ready), 0);
    chk("rw_sys_addr", bus_if.sys_addr, 0);
    chk("rw_rsp_valid", 32'(bus_if.rsp_valid), 0);
    cyc(); cyc();
    rstn = 1'b1;
    ack_en = 1'b1;
    cyc();
    chk("rw_ready_back", 32'(bus_if.cmd_ready), 1);
    bus_if.sys_rdata = 32'h0000_0077;
    push(32'h0000_0077, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0008, 32'h0, 1'b0);
    wait_idle();
    cyc();

    chk("rsp_count", n_rsp, n_push);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
